usb_linestate_mon: RTL and testbench
====================================

Name: usb_linestate_mon

Overview:
Parametrised USB full-speed line-state monitor that replaces the fixed 20-bit suspend/reset timeout counters in the core top level. It sits beside usb_phy and usb_rx_pkt in the clk domain and detects bus reset, suspend and host resume, each with a clock-frequency-derived timeout. It adds remote-wakeup signalling, which the previous logic lacked: it drives K on the bus through a PHY override. It emits level status and single-cycle event strobes for the CSR and event logic.

Parameters:
CLK_FREQ, 48000000, clk frequency in Hz; must be a multiple of 1000000.
T_RESET_US, 10000, SE0 duration (us) qualifying as bus reset.
T_SUSPEND_US, 3000, continuous J idle (us) before suspend.
T_WAKE_IDLE_US, 5000, minimum idle since suspend entry (us) before remote wakeup is allowed.
T_WAKE_DRIVE_US, 2000, duration (us) of the remote-wakeup K drive.
K_FILT_CYC, 48, consecutive K cycles needed to accept a host resume.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous reset, active-low
rx_dp  in  1  synchronised D+ from usb_phy
rx_dn  in  1  synchronised D- from usb_phy
sof_stb  in  1  one-cycle strobe on SOF packet start
wake_ena  in  1  remote wakeup enabled by host (CSR bit)
wake_req  in  1  one-cycle remote wakeup request from software
usb_reset  out  1  level: bus reset in progress
usb_suspend  out  1  level: device suspended
reset_evt  out  1  one-cycle strobe on usb_reset rising
suspend_evt  out  1  one-cycle strobe on suspend entry
resume_evt  out  1  one-cycle strobe on resume acceptance (host K or SOF)
wake_tx_en  out  1  PHY drive override enable
wake_tx_dp  out  1  D+ value while overriding (0)
wake_tx_dn  out  1  D- value while overriding (1)
state  out  3  FSM state code, for debug/CSR

Behaviour:
- Line decode: J = dp1/dn0, K = dp0/dn1, SE0 = dp0/dn0; SE1 is treated as non-J activity.
- Tick constants: N_x = (CLK_FREQ/1000000) * T_x_US. CW = clog2(max N + 1). All counters are CW bits and saturate, never wrap.
- se0_cnt: cleared when the line is not SE0, increments while SE0. idle_cnt: cleared on non-J or sof_stb, increments while J. k_cnt: cleared when the line is not K, increments while K. Both se0_cnt and idle_cnt freeze while wake_tx_en=1.
- States (code): ACTIVE(0), SUSPENDED(1), RESUMING(2), WAKE_WAIT(3), WAKE_DRIVE(4), RESET(5).
- Priority 1, any state except WAKE_DRIVE: if se0_cnt reaches N_RESET, go to RESET; usb_reset=1, reset_evt=1 for that cycle, usb_suspend=0.
- RESET: hold while SE0 continues; on the first non-SE0 cycle go to ACTIVE and clear usb_reset on the next edge. Reset duration is unbounded.
- ACTIVE: if idle_cnt reaches N_SUSPEND, go to SUSPENDED; suspend_evt=1, usb_suspend=1 from the next cycle.
- SUSPENDED: if k_cnt reaches K_FILT_CYC, go to RESUMING with resume_evt=1. If sof_stb=1, go directly to ACTIVE with resume_evt=1. If wake_req=1 and wake_ena=1: go to WAKE_DRIVE when idle_cnt >= N_WAKE_IDLE, else to WAKE_WAIT. wake_req with wake_ena=0 is dropped.
- WAKE_WAIT: when idle_cnt reaches N_WAKE_IDLE, go to WAKE_DRIVE. Host K, SOF or reset preempt it using the SUSPENDED rules; the pending request is discarded.
- WAKE_DRIVE: wake_tx_en=1, dp=0, dn=1 for exactly N_WAKE_DRIVE cycles, then go to RESUMING with resume_evt=1. Not interruptible.
- RESUMING: usb_suspend stays 1. Wait for a non-K cycle (host EOP SE0 or J), then go to ACTIVE; usb_suspend=0 on entry. The SE0 reset rule still applies.
- Simultaneous events: reset beats everything; SOF beats K-filter resume; only one event strobe fires per cycle.
- Outputs are registered; status and strobes change 1 cycle after the qualifying sample.
- Reset (rst_n=0 at posedge): state=ACTIVE, all counters 0, all outputs 0. A reset during WAKE_DRIVE drops wake_tx_en on the next edge.

Test Plan:
Use CLK_FREQ=1000000, T_RESET_US=10, T_SUSPEND_US=30, T_WAKE_IDLE_US=50, T_WAKE_DRIVE_US=20, K_FILT_CYC=4.
- SE0 for 9 cycles then J -> no usb_reset. SE0 for 10 cycles -> reset_evt one pulse, usb_reset=1 until 1 cycle after J, then state=0.
- J idle with sof_stb every 20 cycles -> never suspends. J idle 30 cycles -> suspend_evt pulse, usb_suspend=1, state=1.
- Suspended, K for 3 cycles then J -> stays SUSPENDED. K for 4 cycles -> resume_evt, state=2. SE0 then J -> state=0, usb_suspend=0.
- wake_req at idle_cnt=35 with wake_ena=1 -> WAKE_WAIT until idle 50, then wake_tx_en=1 for exactly 20 cycles, dp=0/dn=1 -> RESUMING. With wake_ena=0 -> no drive.
- Suspended, sof_stb coincident with K-filter completion -> single resume_evt, state=0.
- rst_n low mid WAKE_DRIVE -> wake_tx_en=0 and all outputs 0 next cycle, state=0.

Source files
------------

// File: rtl/usb_linestate_mon.sv
// USB full-speed line-state monitor: bus reset, suspend, host resume detection
// and remote-wakeup K drive, with timeouts derived from the clock frequency.
module usb_linestate_mon #(
    parameter int CLK_FREQ        = 48000000,
    parameter int T_RESET_US      = 10000,
    parameter int T_SUSPEND_US    = 3000,
    parameter int T_WAKE_IDLE_US  = 5000,
    parameter int T_WAKE_DRIVE_US = 2000,
    parameter int K_FILT_CYC      = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dp,
    input  logic       rx_dn,
    input  logic       sof_stb,
    input  logic       wake_ena,
    input  logic       wake_req,
    output logic       usb_reset,
    output logic       usb_suspend,
    output logic       reset_evt,
    output logic       suspend_evt,
    output logic       resume_evt,
    output logic       wake_tx_en,
    output logic       wake_tx_dp,
    output logic       wake_tx_dn,
    output logic [2:0] state
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TPU          = CLK_FREQ / 1000000;
    localparam int N_RESET      = TPU * T_RESET_US;
    localparam int N_SUSPEND    = TPU * T_SUSPEND_US;
    localparam int N_WAKE_IDLE  = TPU * T_WAKE_IDLE_US;
    localparam int N_WAKE_DRIVE = TPU * T_WAKE_DRIVE_US;
    localparam int N_MAX = max2(max2(max2(N_RESET, N_SUSPEND), max2(N_WAKE_IDLE, N_WAKE_DRIVE)), K_FILT_CYC);
    localparam int CW    = $clog2(N_MAX + 1);

    localparam logic [CW-1:0] C_RESET    = CW'(N_RESET);
    localparam logic [CW-1:0] C_SUSPEND  = CW'(N_SUSPEND);
    localparam logic [CW-1:0] C_WIDLE    = CW'(N_WAKE_IDLE);
    localparam logic [CW-1:0] C_DRV_LAST = CW'(N_WAKE_DRIVE - 1);
    localparam logic [CW-1:0] C_KFILT    = CW'(K_FILT_CYC);

    typedef enum logic [2:0] {
        ST_ACTIVE     = 3'd0,
        ST_SUSPENDED  = 3'd1,
        ST_RESUMING   = 3'd2,
        ST_WAKE_WAIT  = 3'd3,
        ST_WAKE_DRIVE = 3'd4,
        ST_RESET      = 3'd5
    } state_t;

    state_t        cur, nxt;
    logic          resume_nxt;
    logic [CW-1:0] se0_cnt, idle_cnt, k_cnt, drv_cnt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // SE1 falls into none of the three classes, so it clears every counter.
    logic line_j, line_k, line_se0;
    assign line_j   =  rx_dp & ~rx_dn;
    assign line_k   = ~rx_dp &  rx_dn;
    assign line_se0 = ~rx_dp & ~rx_dn;

    logic rst_hit, k_hit, idle_ok, wake_go;
    assign rst_hit = (se0_cnt >= C_RESET);
    assign k_hit   = (k_cnt >= C_KFILT);
    assign idle_ok = (idle_cnt >= C_WIDLE);
    assign wake_go = wake_req & wake_ena;

    // Our own K drive must not look like bus activity or an SE0 run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            se0_cnt  <= '0;
            idle_cnt <= '0;
            k_cnt    <= '0;
            drv_cnt  <= '0;
        end else begin
            if (!wake_tx_en) begin
                se0_cnt  <= line_se0 ? sat_inc(se0_cnt) : '0;
                idle_cnt <= (line_j && !sof_stb) ? sat_inc(idle_cnt) : '0;
            end
            k_cnt   <= line_k ? sat_inc(k_cnt) : '0;
            drv_cnt <= (cur == ST_WAKE_DRIVE) ? sat_inc(drv_cnt) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cur <= ST_ACTIVE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt        = cur;
        resume_nxt = 1'b0;
        case (cur)
            ST_ACTIVE: begin
                if (rst_hit)                     nxt = ST_RESET;
                else if (idle_cnt >= C_SUSPEND)  nxt = ST_SUSPENDED;
            end
            ST_SUSPENDED, ST_WAKE_WAIT: begin
                if (rst_hit) begin
                    nxt = ST_RESET;
                end else if (sof_stb) begin
                    nxt        = ST_ACTIVE;
                    resume_nxt = 1'b1;
                end else if (k_hit) begin
                    nxt        = ST_RESUMING;
                    resume_nxt = 1'b1;
                end else if (cur == ST_SUSPENDED && wake_go) begin
                    nxt = idle_ok ? ST_WAKE_DRIVE : ST_WAKE_WAIT;
                end else if (cur == ST_WAKE_WAIT && idle_ok) begin
                    nxt = ST_WAKE_DRIVE;
                end
            end
            ST_WAKE_DRIVE: begin
                if (drv_cnt == C_DRV_LAST) begin
                    nxt        = ST_RESUMING;
                    resume_nxt = 1'b1;
                end
            end
            ST_RESUMING: begin
                if (rst_hit)            nxt = ST_RESET;
                else if (k_cnt == '0)   nxt = ST_ACTIVE;
            end
            ST_RESET: begin
                if (se0_cnt == '0)      nxt = ST_ACTIVE;
            end
            default: nxt = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            usb_reset   <= 1'b0;
            usb_suspend <= 1'b0;
            reset_evt   <= 1'b0;
            suspend_evt <= 1'b0;
            resume_evt  <= 1'b0;
            wake_tx_en  <= 1'b0;
            wake_tx_dn  <= 1'b0;
        end else begin
            usb_reset   <= (nxt == ST_RESET);
            usb_suspend <= (nxt == ST_SUSPENDED) || (nxt == ST_RESUMING) ||
                           (nxt == ST_WAKE_WAIT) || (nxt == ST_WAKE_DRIVE);
            reset_evt   <= (nxt == ST_RESET) && (cur != ST_RESET);
            suspend_evt <= (cur == ST_ACTIVE) && (nxt == ST_SUSPENDED);
            resume_evt  <= resume_nxt;
            wake_tx_en  <= (nxt == ST_WAKE_DRIVE);
            wake_tx_dn  <= (nxt == ST_WAKE_DRIVE);
        end
    end

    assign wake_tx_dp = 1'b0;
    assign state      = cur;
endmodule

// File: tb/tb_usb_linestate_mon.sv
// Bench for usb_linestate_mon: directed vector table, a drive-length sequence,
// then random line activity checked against a run-length reference model.
module tb_usb_linestate_mon;
    localparam int NR = 10, NS = 30, NW = 50, ND = 20, KF = 4;
    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, L0 = 2'b00, L1 = 2'b11;
    localparam int M_ACT = 0, M_SUSP = 1, M_RESUM = 2, M_WAIT = 3, M_DRIVE = 4, M_RESET = 5;

    logic clk = 1'b0;
    logic rst_n, rx_dp, rx_dn, sof_stb, wake_ena, wake_req;
    logic usb_reset, usb_suspend, reset_evt, suspend_evt, resume_evt;
    logic wake_tx_en, wake_tx_dp, wake_tx_dn;
    logic [2:0] state;

    always #5 clk = ~clk;

    usb_linestate_mon #(
        .CLK_FREQ(1000000), .T_RESET_US(10), .T_SUSPEND_US(30),
        .T_WAKE_IDLE_US(50), .T_WAKE_DRIVE_US(20), .K_FILT_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_dp(rx_dp), .rx_dn(rx_dn),
        .sof_stb(sof_stb), .wake_ena(wake_ena), .wake_req(wake_req),
        .usb_reset(usb_reset), .usb_suspend(usb_suspend),
        .reset_evt(reset_evt), .suspend_evt(suspend_evt), .resume_evt(resume_evt),
        .wake_tx_en(wake_tx_en), .wake_tx_dp(wake_tx_dp), .wake_tx_dn(wake_tx_dn),
        .state(state)
    );

    logic [10:0] dut_v;
    assign dut_v = {state, usb_reset, usb_suspend, reset_evt, suspend_evt, resume_evt,
                    wake_tx_en, wake_tx_dp, wake_tx_dn};

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input int idx, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%b expected=%b", nm, idx, act, exp);
        end
    endtask

    // Reference model: unbounded run lengths of each line class plus a count
    // of drive cycles already spent; expectations are for the outputs after the edge.
    int m_st, m_se0, m_idle, m_k, m_drv;
    bit m_tx;
    logic [10:0] m_exp;

    task automatic model_step();
        int ns;
        bit res, is_j, is_k, is_se0;
        if (!rst_n) begin
            m_st = M_ACT; m_se0 = 0; m_idle = 0; m_k = 0; m_drv = 0; m_tx = 0;
            m_exp = '0;
            return;
        end
        is_j = {rx_dp, rx_dn} == LJ;
        is_k = {rx_dp, rx_dn} == LK;
        is_se0 = {rx_dp, rx_dn} == L0;
        ns = m_st; res = 0;
        if (m_st != M_DRIVE && m_st != M_RESET && m_se0 >= NR) ns = M_RESET;
        else if (m_st == M_ACT) begin
            if (m_idle >= NS) ns = M_SUSP;
        end else if (m_st == M_SUSP || m_st == M_WAIT) begin
            if (sof_stb) begin ns = M_ACT; res = 1; end
            else if (m_k >= KF) begin ns = M_RESUM; res = 1; end
            else if (m_st == M_SUSP && wake_req && wake_ena) ns = (m_idle >= NW) ? M_DRIVE : M_WAIT;
            else if (m_st == M_WAIT && m_idle >= NW) ns = M_DRIVE;
        end else if (m_st == M_DRIVE) begin
            if (m_drv == ND) begin ns = M_RESUM; res = 1; end
        end else if (m_st == M_RESUM) begin
            if (m_k == 0) ns = M_ACT;
        end else if (m_st == M_RESET) begin
            if (m_se0 == 0) ns = M_ACT;
        end
        m_drv = (ns == M_DRIVE) ? m_drv + 1 : 0;
        if (!m_tx) begin
            m_se0  = is_se0 ? m_se0 + 1 : 0;
            m_idle = (is_j && !sof_stb) ? m_idle + 1 : 0;
        end
        m_k = is_k ? m_k + 1 : 0;
        m_exp = {3'(ns), ns == M_RESET, ns >= M_SUSP && ns <= M_DRIVE,
                 ns == M_RESET && m_st != M_RESET, m_st == M_ACT && ns == M_SUSP, res,
                 ns == M_DRIVE, 1'b0, ns == M_DRIVE};
        m_tx = (ns == M_DRIVE);
        m_st = ns;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic rst_n; logic [1:0] line; logic sof, wena, wreq; int cyc;
        logic [2:0] st; logic rs, su; logic [2:0] ev; logic tx;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] l, input logic s, input logic we,
                                input logic wr, input int c, input logic [2:0] st,
                                input logic rs, input logic su, input logic [2:0] ev, input logic tx);
        vec_t v;
        v.rst_n = r; v.line = l; v.sof = s; v.wena = we; v.wreq = wr; v.cyc = c;
        v.st = st; v.rs = rs; v.su = su; v.ev = ev; v.tx = tx;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        int n, run;
        logic [1:0] ln;
        rst_n = 0; {rx_dp, rx_dn} = LJ; sof_stb = 0; wake_ena = 0; wake_req = 0;
        ln = LJ; run = 0;
        @(negedge clk);

        // ev = {reset_evt, suspend_evt, resume_evt}
        tbl.push_back(mk(0, LJ, 0, 0, 0,  2, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, L0, 0, 0, 0,  9, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, L0, 0, 0, 0, 10, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, L0, 0, 0, 0,  1, 5, 1, 0, 3'b100, 0));
        tbl.push_back(mk(1, L0, 0, 0, 0,  5, 5, 1, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 5, 1, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0));
        for (int r = 0; r < 3; r++) begin
            tbl.push_back(mk(1, LJ, 1, 0, 0,  1, 0, 0, 0, 3'b000, 0));
            tbl.push_back(mk(1, LJ, 0, 0, 0, 19, 0, 0, 0, 3'b000, 0));
        end
        tbl.push_back(mk(1, LJ, 0, 0, 0, 11, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 1, 0, 1, 3'b010, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LK, 0, 0, 0,  3, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LK, 0, 0, 0,  4, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LK, 0, 0, 0,  1, 2, 0, 1, 3'b001, 0));
        tbl.push_back(mk(1, LK, 0, 0, 0,  2, 2, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, L0, 0, 0, 0,  1, 2, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0, 29, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 1, 0, 1, 3'b010, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0,  4, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 1,  1, 3, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0, 13, 3, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0,  1, 3, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0,  1, 4, 0, 1, 3'b000, 1));
        tbl.push_back(mk(1, LK, 0, 1, 0, 19, 4, 0, 1, 3'b000, 1));
        tbl.push_back(mk(1, LK, 0, 1, 0,  1, 2, 0, 1, 3'b001, 0));
        tbl.push_back(mk(1, LK, 0, 1, 0,  3, 2, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, L0, 0, 1, 0,  1, 2, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0,  1, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0, 29, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 1, 0, 1, 3'b010, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 1,  1, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0, 30, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LK, 0, 0, 0,  4, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LK, 1, 0, 0,  1, 0, 0, 0, 3'b001, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0, 29, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 1, 0, 1, 3'b010, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0, 18, 1, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 1,  1, 3, 0, 1, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 1, 0,  1, 4, 0, 1, 3'b000, 1));
        tbl.push_back(mk(1, LK, 0, 1, 0,  5, 4, 0, 1, 3'b000, 1));
        tbl.push_back(mk(0, LK, 0, 1, 0,  1, 0, 0, 0, 3'b000, 0));
        tbl.push_back(mk(1, LJ, 0, 0, 0,  1, 0, 0, 0, 3'b000, 0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; {rx_dp, rx_dn} = tbl[i].line;
            sof_stb = tbl[i].sof; wake_ena = tbl[i].wena; wake_req = tbl[i].wreq;
            repeat (tbl[i].cyc) tick();
            chk("vec", i, dut_v, {tbl[i].st, tbl[i].rs, tbl[i].su, tbl[i].ev,
                                  tbl[i].tx, 1'b0, tbl[i].tx});
        end

        // Wake request with enough idle already banked goes straight to the drive.
        rst_n = 0; {rx_dp, rx_dn} = LJ; sof_stb = 0; wake_ena = 0; wake_req = 0;
        tick();
        rst_n = 1;
        repeat (31) tick();
        chk("hs_susp", 0, 11'(state), 11'(M_SUSP));
        repeat (20) tick();
        wake_ena = 1; wake_req = 1;
        tick();
        wake_req = 0;
        chk("hs_direct", 0, {8'(state), wake_tx_en, wake_tx_dp, wake_tx_dn}, {8'(M_DRIVE), 3'b101});
        n = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (wake_tx_en) n++;
            else break;
        end
        chk("hs_drive_len", 0, 11'(n), 11'(ND));
        chk("hs_after_drive", 0, {8'(state), resume_evt, wake_tx_en, usb_suspend},
            {8'(M_RESUM), 3'b101});

        // Random line activity against the reference model.
        rst_n = 0; wake_ena = 0;
        tick();
        chk("rand_rst", 0, dut_v, m_exp);
        for (int c = 0; c < 4000 && failures < 40; c++) begin
            if (run == 0) begin
                int r;
                r = $urandom_range(0, 99);
                ln = (r < 40) ? LJ : (r < 65) ? LK : (r < 90) ? L0 : L1;
                run = (ln == LJ) ? $urandom_range(1, 80) : $urandom_range(1, 16);
                wake_ena = 1'($urandom_range(0, 1));
            end
            run--;
            {rx_dp, rx_dn} = ln;
            sof_stb  = ($urandom_range(0, 59) == 0);
            wake_req = ($urandom_range(0, 24) == 0);
            rst_n    = ($urandom_range(0, 1999) != 0);
            tick();
            chk("rand", c, dut_v, m_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
